mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/arb_pick.sv | 19 +
 rtl/mem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the pseudoram arbiter (video line fetch vs host).
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
   typedef enum logic {OWN_VID, OWN_HOST} owner_t;

   localparam int LINE_BYTES = 40;
   localparam int FAIR_LIMIT = 3;

endpackage

// File: rtl/arb_pick.sv
// Combinational owner select: video first, unless the fairness count has hit its limit.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic       vid_req,
   input  logic       host_req,
   input  logic [1:0] fair_cnt,
   output logic       any_req,
   output owner_t     owner
);

   always_comb begin
      any_req = vid_req | host_req;
      owner   = OWN_VID;
      if (host_req && (!vid_req || fair_cnt == 2'(FAIR_LIMIT)))
         owner = OWN_HOST;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Pseudoram arbiter between video line fetches and host accesses.
// Optional host fairness counter enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BUSY_TIMEOUT = 4,
   parameter int ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_done,
   output logic              vid_bank,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   output logic              host_ack,
   output logic              host_done,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read_strobe,
   output logic              mem_write_strobe,
   output logic              err
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   state_t        state, state_nxt;
   owner_t        owner_q, pick;
   logic          we_q;
   logic          any_req;
   logic          run_q0, run_q1;
   logic          grant, timeout, finish;
   logic [TW-1:0] busy_cnt;
   logic [1:0]    fair_cnt;

   // Reset release is re-timed so no grant races the deassertion edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q0 <= 1'b0;
         run_q1 <= 1'b0;
      end else begin
         run_q0 <= 1'b1;
         run_q1 <= run_q0;
      end
   end

   arb_pick u_pick (
      .vid_req  (vid_req),
      .host_req (host_req),
      .fair_cnt (fair_cnt),
      .any_req  (any_req),
      .owner    (pick)
   );

   assign grant   = (state == IDLE) && mem_ready && any_req && run_q1;
   assign timeout = (state == WAIT_BUSY) && mem_ready && (busy_cnt == TW'(BUSY_TIMEOUT - 1));
   assign finish  = ((state == WAIT_DONE) && mem_ready) || timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (grant) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (!mem_ready) state_nxt = WAIT_DONE;
                    else if (timeout) state_nxt = IDLE;
         WAIT_DONE: if (mem_ready) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      vid_ack          = grant && (pick == OWN_VID);
      host_ack         = grant && (pick == OWN_HOST);
      mem_read_strobe  = (state == ISSUE) && ((owner_q == OWN_VID) || !we_q);
      mem_write_strobe = (state == ISSUE) && (owner_q == OWN_HOST) && we_q;
      vid_done         = finish && (owner_q == OWN_VID);
      host_done        = finish && (owner_q == OWN_HOST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= OWN_VID;
         we_q     <= 1'b0;
         mem_addr <= '0;
         busy_cnt <= '0;
         err      <= 1'b0;
         vid_bank <= 1'b0;
      end else begin
         if (grant) begin
            owner_q  <= pick;
            we_q     <= (pick == OWN_HOST) && host_we;
            mem_addr <= (pick == OWN_VID) ? vid_addr : host_addr;
         end
         if (state == ISSUE)          busy_cnt <= '0;
         else if (state == WAIT_BUSY) busy_cnt <= busy_cnt + TW'(1);
         if (timeout)  err      <= 1'b1;
         if (vid_done) vid_bank <= ~vid_bank;
      end
   end

`ifdef MEM_ARB_FAIRNESS_EN
   // Counts video wins while the host waits; any host grant starts over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fair_cnt <= 2'd0;
      end else if (grant) begin
         if (pick == OWN_HOST)
            fair_cnt <= 2'd0;
         else if (host_req && fair_cnt != 2'(FAIR_LIMIT))
            fair_cnt <= fair_cnt + 2'd1;
      end
   end
`else
   assign fair_cnt = 2'd0;
`endif

endmodule
